// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Summary  : Shared opcode encodings, FSM state type and operand-width helper
//            for the keypad calculator arithmetic core.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Operation select encodings
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Operand/result width in bits for a given number of hex digits
    function automatic int calc_width(input int digits);
        return 4 * digits;
    endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Summary  : Iterative shift-add unsigned multiplier, one partial product per
//            clock. The first partial product is folded in on the start edge,
//            the remaining W-1 while busy; done pulses with the full 2W-bit
//            product already held in the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;

    // Operand latch plus one shift-add step per cycle until the counter expires
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_acc    <= b[0] ? {{W{1'b0}}, a} : '0;
                r_mcand  <= {{(W-1){1'b0}}, a, 1'b0};
                r_mplier <= b >> 1;
                r_cnt    <= CW'(W - 1);
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule : seq_multiplier
`default_nettype wire

// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
// Module   : calc_engine
// Summary  : Keypad calculator core: hex operand entry, single-cycle
//            add/sub/pass ALU, iterative multiply and a small result memory.
// Revision : 1.0 - initial release
// ============================================================================
module calc_engine
    import calc_pkg::*;
#(
    parameter  int DIGITS    = 2,
    parameter  int MEM_DEPTH = 4,
    localparam int W         = calc_width(DIGITS),
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    input  logic          sel_b,
    input  logic          clr_entry,
    input  logic [1:0]    op,
    input  logic          op_start,
    input  logic          save,
    input  logic          load,
    input  logic [AW-1:0] mem_addr,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    output logic [W-1:0]  q,
    output logic          overflow,
    output logic          busy,
    output logic          done
);

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_q;
    logic           r_ovf;
    logic           r_alu_done;
    logic [W-1:0]   r_mem [MEM_DEPTH];

    logic           w_idle;
    logic           w_alu_go;
    logic           w_mul_go;
    logic           w_addr_ok;
    logic [W-1:0]   w_mem_rd;
    logic [W-1:0]   w_sel_opnd;
    logic [W-1:0]   w_opnd_nxt;
    logic           w_opnd_we;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_alu_q;
    logic           w_alu_ovf;
    logic           w_mul_busy;
    logic           w_mul_done;
    logic [2*W-1:0] w_product;

    // Out-of-range slots are treated as absent; reads of them return zero
    assign w_addr_ok = (32'(mem_addr) < 32'(MEM_DEPTH));
    assign w_mem_rd  = w_addr_ok ? r_mem[mem_addr] : '0;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: only a multiply leaves IDLE, FIN lasts exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_mul_go)   w_state_nxt = MUL;
            MUL:     if (w_mul_done) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: request qualification, busy and the completion pulse
    always_comb begin
        w_idle   = (r_state == IDLE);
        w_alu_go = w_idle && op_start && (op != OP_MUL);
        w_mul_go = w_idle && op_start && (op == OP_MUL) && !w_mul_busy;
        busy     = (r_state == MUL);
        done     = r_alu_done || (r_state == FIN);
    end

    // Operand update arbitration: clear beats load beats digit entry
    always_comb begin
        w_sel_opnd = sel_b ? r_b : r_a;
        w_opnd_nxt = w_sel_opnd;
        w_opnd_we  = 1'b0;
        if (w_idle) begin
            if (clr_entry) begin
                w_opnd_we  = 1'b1;
                w_opnd_nxt = '0;
            end else if (load) begin
                w_opnd_we  = w_addr_ok;
                w_opnd_nxt = w_mem_rd;
            end else if (key_valid) begin
                w_opnd_we  = 1'b1;
                w_opnd_nxt = (w_sel_opnd << 4) | W'(key_code);
            end
        end
    end

    // Operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_opnd_we) begin
            if (sel_b) begin
                r_b <= w_opnd_nxt;
            end else begin
                r_a <= w_opnd_nxt;
            end
        end
    end

    // Result memory; a same-cycle load sees the contents before this write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_idle && save && w_addr_ok) begin
            r_mem[mem_addr] <= r_q;
        end
    end

    // Single-cycle ALU for add, subtract and pass-through
    always_comb begin
        w_sum     = '0;
        w_alu_q   = '0;
        w_alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                w_sum     = {1'b0, r_a} + {1'b0, r_b};
                w_alu_q   = w_sum[W-1:0];
                w_alu_ovf = w_sum[W];
            end
            OP_SUB: begin
                w_alu_q   = r_a - r_b;
                w_alu_ovf = (r_a < r_b);
            end
            OP_PASS: begin
                w_alu_q = r_a;
            end
            default: ;
        endcase
    end

    // Result registers, written by the ALU or at the end of a multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= '0;
            r_ovf      <= 1'b0;
            r_alu_done <= 1'b0;
        end else begin
            r_alu_done <= w_alu_go;
            if (w_alu_go) begin
                r_q   <= w_alu_q;
                r_ovf <= w_alu_ovf;
            end else if ((r_state == MUL) && w_mul_done) begin
                r_q   <= w_product[W-1:0];
                r_ovf <= |w_product[2*W-1:W];
            end
        end
    end

    seq_multiplier #(
        .W (W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_go),
        .a       (r_a),
        .b       (r_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    assign a        = r_a;
    assign b        = r_b;
    assign q        = r_q;
    assign overflow = r_ovf;

endmodule : calc_engine
`default_nettype wire
